// File: rtl/lfsr_draw_sched_pkg.sv
// Shared types, constants and LFSR helpers for the draw scheduler.
// The polynomial is x^16+x^14+x^13+x^11+1, which gives a maximal period of 2^16-1.
package lfsr_draw_sched_pkg;

    localparam int                LFSR_W       = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
    localparam logic [LFSR_W-1:0] RST_SEED_DEF = 16'h1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        LOAD  = 2'd2
    } sched_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

    // All-zero is the lockup state, so a zero seed is replaced by the default.
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] seed,
                                                   input logic [LFSR_W-1:0] dflt);
        return (seed == '0) ? dflt : seed;
    endfunction

endpackage

// File: rtl/lfsr16_step_core.sv
// 16-bit Fibonacci LFSR register: advances one step when en is high, and a load takes priority over en.
// The next state is exposed combinationally. Latency is one cycle, and there is no backpressure.
module lfsr16_step_core
    import lfsr_draw_sched_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = RST_SEED_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_value,
    output logic [LFSR_W-1:0] state,
    output logic [LFSR_W-1:0] state_next
);

    always_comb begin
        state_next = lfsr_next(state);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEED;
        end else if (load) begin
            state <= seed_fix(load_value, SEED);
        end else if (en) begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/lfsr_draw_sched.sv
// Round-robin sharing of one LFSR among NUM_REQ requesters. A req sampled at one edge yields a gnt/rnd_data after the next edge.
// Backpressure: at most one grant per cycle. No grants while run=0, in the seed_load cycle, or during LOAD.
module lfsr_draw_sched
    import lfsr_draw_sched_pkg::*;
#(
    parameter int                NUM_REQ  = 4,
    parameter logic [LFSR_W-1:0] RST_SEED = RST_SEED_DEF,
    parameter int                CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [LFSR_W-1:0]  rnd_data,
    input  logic               seed_load,
    input  logic [LFSR_W-1:0]  seed_value,
    output logic               busy,
    output logic [CNT_W-1:0]   draw_count,
    output logic               wrap
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_t       state;
    logic [PTR_W-1:0]   ptr;
    logic [LFSR_W-1:0]  seed_reg;
    logic [LFSR_W-1:0]  lfsr;
    logic [LFSR_W-1:0]  lfsr_adv;
    logic [PTR_W-1:0]   win;
    logic [NUM_REQ-1:0] win_oh;
    logic               found;
    logic               grant;

    lfsr16_step_core #(
        .SEED (RST_SEED)
    ) u_lfsr (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (grant),
        .load       (seed_load),
        .load_value (seed_value),
        .state      (lfsr),
        .state_next (lfsr_adv)
    );

    // Circular search starting at the round-robin pointer.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx    = '0;
        win    = '0;
        found  = 1'b0;
        win_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        win_oh[win] = 1'b1;
        grant = (state != LOAD) && run && found && !seed_load;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            seed_reg   <= RST_SEED;
            gnt        <= '0;
            rnd_data   <= '0;
            busy       <= 1'b0;
            draw_count <= '0;
            wrap       <= 1'b0;
        end else begin
            gnt  <= grant ? win_oh : '0;
            wrap <= grant && (lfsr_adv == seed_reg);
            busy <= seed_load;

            if (seed_load) begin
                state      <= LOAD;
                seed_reg   <= seed_fix(seed_value, RST_SEED);
                draw_count <= '0;
            end else begin
                case (state)
                    IDLE:    if (run && |req) state <= SERVE;
                    SERVE:   if (!run || !(|req)) state <= IDLE;
                    LOAD:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end

            // grant already excludes seed_load, so the counter clear above cannot collide.
            if (grant) begin
                rnd_data   <= lfsr;
                ptr        <= PTR_W'((int'(win) + 1) % NUM_REQ);
                draw_count <= draw_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lfsr_draw_sched.sv
// Directed bench for lfsr_draw_sched: hand-computed sequences plus one full-period run.
module tb_lfsr_draw_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [15:0] rnd_data;
    logic        seed_load;
    logic [15:0] seed_value;
    logic        busy;
    logic [31:0] draw_count;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_draw_sched #(
        .NUM_REQ  (4),
        .RST_SEED (16'h1001),
        .CNT_W    (32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .req        (req),
        .gnt        (gnt),
        .rnd_data   (rnd_data),
        .seed_load  (seed_load),
        .seed_value (seed_value),
        .busy       (busy),
        .draw_count (draw_count),
        .wrap       (wrap)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle; inputs change and outputs are read 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    initial begin
        int          wrap_cnt;
        int          wrap_at;
        int          seq_bad;
        logic [15:0] m_lfsr;

        run        = 1'b0;
        req        = 4'b0000;
        seed_load  = 1'b0;
        seed_value = 16'h0000;
        do_reset();

        chk("rst_gnt",   gnt, 0);
        chk("rst_rnd",   rnd_data, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_cnt",   draw_count, 0);
        chk("rst_wrap",  wrap, 0);

        // Single requester, three draws.
        run = 1'b1;
        req = 4'b0001;
        tick(); chk("s1_gnt0", gnt, 4'b0001); chk("s1_rnd0", rnd_data, 16'h1001);
        tick(); chk("s1_gnt1", gnt, 4'b0001); chk("s1_rnd1", rnd_data, 16'h2003);
        tick(); chk("s1_gnt2", gnt, 4'b0001); chk("s1_rnd2", rnd_data, 16'h4007);
        chk("s1_cnt", draw_count, 3);

        // All requesters: rotation from pointer 0.
        req = 4'b0000;
        do_reset();
        run = 1'b1;
        req = 4'b1111;
        tick(); chk("rr_gnt0", gnt, 4'b0001); chk("rr_rnd0", rnd_data, 16'h1001);
        tick(); chk("rr_gnt1", gnt, 4'b0010); chk("rr_rnd1", rnd_data, 16'h2003);
        tick(); chk("rr_gnt2", gnt, 4'b0100); chk("rr_rnd2", rnd_data, 16'h4007);
        tick(); chk("rr_gnt3", gnt, 4'b1000); chk("rr_rnd3", rnd_data, 16'h800E);
        tick(); chk("rr_gnt4", gnt, 4'b0001); chk("rr_rnd4", rnd_data, 16'h001D);
        chk("rr_cnt", draw_count, 5);
        req = 4'b0000;
        tick(); chk("rr_idle_gnt", gnt, 0); chk("rr_hold_rnd", rnd_data, 16'h001D);

        // Mid-stream reseed; pointer is 1, lfsr is 003A.
        req = 4'b0011;
        tick(); chk("sl_pre_gnt", gnt, 4'b0010); chk("sl_pre_rnd", rnd_data, 16'h003A);
        seed_load  = 1'b1;
        seed_value = 16'hACE1;
        tick(); chk("sl_gap0", gnt, 0); chk("sl_busy0", busy, 1);
        seed_load = 1'b0;
        tick(); chk("sl_gap1", gnt, 0); chk("sl_busy1", busy, 0);
        tick(); chk("sl_gnt", gnt, 4'b0001); chk("sl_rnd", rnd_data, 16'hACE1);
        chk("sl_cnt", draw_count, 1);
        tick(); chk("sl_gnt2", gnt, 4'b0010); chk("sl_rnd2", rnd_data, 16'h59C3);
        chk("sl_cnt2", draw_count, 2);

        // Zero seed is substituted with the reset seed.
        req        = 4'b0001;
        seed_load  = 1'b1;
        seed_value = 16'h0000;
        tick(); chk("z_gap0", gnt, 0);
        seed_load = 1'b0;
        tick(); chk("z_gap1", gnt, 0);
        tick(); chk("z_gnt", gnt, 4'b0001); chk("z_rnd", rnd_data, 16'h1001);

        // Run gate: pointer is 1, lfsr is 2003.
        req = 4'b0101;
        tick(); chk("run_gnt", gnt, 4'b0100); chk("run_rnd", rnd_data, 16'h2003);
        run = 1'b0;
        tick(); chk("stop_gnt0", gnt, 0);
        tick(); chk("stop_gnt1", gnt, 0); chk("stop_rnd", rnd_data, 16'h2003);
        chk("stop_cnt", draw_count, 2);
        run = 1'b1;
        tick(); chk("resume_gnt", gnt, 4'b0001); chk("resume_rnd", rnd_data, 16'h4007);
        tick(); chk("resume_gnt2", gnt, 4'b0100); chk("resume_rnd2", rnd_data, 16'h800E);

        // Asynchronous reset mid-SERVE, between edges.
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_gnt",  gnt, 0);
        chk("arst_rnd",  rnd_data, 0);
        chk("arst_cnt",  draw_count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_wrap", wrap, 0);
        tick();
        reset_n = 1'b1;
        req     = 4'b0001;
        tick(); chk("arst_gnt1", gnt, 4'b0001); chk("arst_rnd1", rnd_data, 16'h1001);

        // Full period from the reset seed.
        req = 4'b0000;
        do_reset();
        run      = 1'b1;
        req      = 4'b0001;
        m_lfsr   = 16'h1001;
        wrap_cnt = 0;
        wrap_at  = 0;
        seq_bad  = 0;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            if (rnd_data !== m_lfsr || gnt !== 4'b0001) seq_bad++;
            m_lfsr = m_step(m_lfsr);
            if (wrap === 1'b1) begin
                wrap_cnt++;
                wrap_at = i;
            end
        end
        chk("per_seq_bad", seq_bad, 0);
        chk("per_wrap_cnt", wrap_cnt, 1);
        chk("per_wrap_at", wrap_at, 65535);
        chk("per_cnt", draw_count, 65535);
        tick();
        chk("per_next_rnd", rnd_data, 16'h1001);
        chk("per_next_wrap", wrap, 0);
        chk("per_cnt_over", draw_count, 65536);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
